interrupt_gateway_bank: RTL and testbench
=========================================

// Module: interrupt_gateway_bank
// PURPOSE
// - Per-source interrupt gateway between raw device interrupt wires and the PLIC-facing interrupt buffers.
// - Synchronises each async source, applies level or edge semantics, and presents one valid/ready request per source.
// - Holds one request in flight per source until the PLIC signals completion; records lost edges.
// PARAMETERS
// - N_SRC        8   number of interrupt sources (1..64)
// - SYNC_STAGES  3   synchroniser depth per source (2..4)
// - EDGE_MASK    '0  N_SRC bits; bit i=1 -> source i edge-triggered, 0 -> level-triggered
// PORTS
// - clock            in   1       sole clock
// - reset            in   1       asynchronous, active-high; clears all state
// - irq_in           in   N_SRC   raw interrupt levels, asynchronous to clock
// - gw_valid         out  N_SRC   request pending toward PLIC, per source
// - gw_ready         in   N_SRC   PLIC accepts request i when gw_valid[i]&gw_ready[i]
// - gw_complete      in   N_SRC   PLIC completion pulse, per source
// - edge_overrun     out  N_SRC   sticky: edge arrived while edge already pending
// - overrun_clr      in   N_SRC   clears edge_overrun[i] (one-cycle pulse)
// BEHAVIOUR
// - Reset: sync chains, prev_sync, pending, inflight, edge_overrun all 0; gw_valid=0 throughout and after reset.
// - sync[i] = irq_in[i] after SYNC_STAGES flops; prev_sync[i] = sync[i] delayed 1 cycle.
// - Level source: gw_valid[i] = sync[i] & ~inflight[i] (combinational from regs).
//   Latency irq_in rise -> gw_valid: SYNC_STAGES cycles. Deassert before accept drops gw_valid (no memory).
// - Edge source: rise = sync[i] & ~prev_sync[i]; pending[i] set on rise (registered);
//   gw_valid[i] = pending[i] & ~inflight[i]. Latency irq_in rise -> gw_valid: SYNC_STAGES+1 cycles.
// - Accept (gw_valid&gw_ready): inflight[i]<=1 next cycle; edge: pending[i]<=0 unless rise same cycle (rise wins, stays 1).
// - rise while pending[i]=1 and not same-cycle accept: pending stays 1, edge_overrun[i]<=1.
// - rise while inflight & !pending: pending<=1 (one edge buffered), no overrun.
// - gw_complete[i] with inflight[i]=1: inflight<=0 next cycle; gw_valid may re-assert the following cycle.
// - gw_complete[i] with inflight[i]=0: ignored, no state change.
// - gw_complete and accept same cycle impossible (valid low while inflight); if complete coincides with
//   inflight clear, one-cycle bubble required: gw_valid stays 0 in the cycle complete is sampled.
// - overrun_clr and new overrun same cycle: set wins.
// - gw_ready without gw_valid: ignored. Sources fully independent; no arbitration here.
// - Reset mid-operation: inflight dropped; a still-high level source re-requests SYNC_STAGES cycles after release.
// STATE (per source): IDLE(!pend,!infl) -> PEND(valid) -> INFLIGHT -> IDLE on complete;
//   edge only: INFLIGHT+PEND on rise during inflight -> PEND on complete.
// STRUCTURE
// - Package intr_gw_pkg: SYNC_STAGES_DEFAULT, N_SRC_MAX=64, gateway state enum {GW_IDLE,GW_PEND,GW_INFL,GW_INFL_PEND}.
// - Sub-module interrupt_gateway_cell: one source (sync chain, edge detect, pending/inflight, overrun);
//   bank generates N_SRC instances, EDGE_MASK[i] passed as per-cell parameter. No logic outside generate loop.
// TESTING
// - Level: irq_in[0]=1 held, gw_ready=1 -> gw_valid[0] high cycle 3, accept, low; complete -> valid again 2 cycles later.
// - Edge (EDGE_MASK=8'h02): pulse irq_in[1] 1-cycle-wide x1 -> gw_valid[1] at cycle 4; after accept stays 0 though irq_in low.
// - Edge buffering: accept, then 2 edges before complete -> after complete exactly one re-request, edge_overrun[1]=1;
//   overrun_clr[1] pulse -> 0.
// - Spurious: gw_complete[2] while idle and gw_ready without valid -> no state or output change on any source.
// - Reset mid-flight: source 0 inflight, assert reset 1 cycle with irq_in[0]=1 -> gw_valid[0]=0 during reset, re-asserts 3 cycles after release.
// - Independence: all 8 sources active, random ready/complete -> per-source scoreboard: one accept per complete, no cross-talk.

Source files
------------

// File: rtl/intr_gw_pkg.sv
// Shared definitions for the interrupt gateway bank: limits, per-source state
// encoding and the PLIC-side control bundle handed to each gateway cell.
package intr_gw_pkg;

  localparam int SYNC_STAGES_DEFAULT = 3;
  localparam int N_SRC_MAX           = 64;

  // Bit 0 = pending, bit 1 = inflight.
  typedef enum logic [1:0] {
    GW_IDLE      = 2'b00,
    GW_PEND      = 2'b01,
    GW_INFL      = 2'b10,
    GW_INFL_PEND = 2'b11
  } gw_state_e;

  typedef struct packed {
    logic ready;
    logic complete;
    logic overrun_clr;
  } gw_plic_req_t;

endpackage

// File: rtl/interrupt_gateway_cell.sv
// One interrupt source: synchroniser, rise detect, pending/inflight tracking
// and the sticky lost-edge flag.
module interrupt_gateway_cell
  import intr_gw_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEFAULT,
  parameter bit IS_EDGE     = 1'b0
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         irq,
  input  gw_plic_req_t req,
  output logic         gw_valid,
  output logic         edge_overrun
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync;
  logic                   prev_sync;
  logic                   rise;
  logic                   accept;
  logic                   ovr_set;
  gw_state_e              state_q;
  gw_state_e              state_d;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync_q    <= '0;
      prev_sync <= 1'b0;
    end else begin
      sync_q    <= {sync_q[SYNC_STAGES-2:0], irq};
      prev_sync <= sync;
    end
  end

  assign sync = sync_q[SYNC_STAGES-1];
  // Level sources never see a rise, so they only ever use IDLE and INFL.
  assign rise = IS_EDGE & sync & ~prev_sync;

  always_comb begin
    gw_valid = 1'b0;
    if (IS_EDGE) gw_valid = (state_q == GW_PEND);
    else         gw_valid = sync & (state_q == GW_IDLE);
  end

  assign accept = gw_valid & req.ready;

  always_comb begin
    state_d = state_q;
    ovr_set = 1'b0;
    case (state_q)
      GW_IDLE: begin
        if (accept)    state_d = GW_INFL;
        else if (rise) state_d = GW_PEND;
      end
      GW_PEND: begin
        // A rise coinciding with the accept is kept as the next request.
        if (accept)    state_d = rise ? GW_INFL_PEND : GW_INFL;
        else if (rise) ovr_set = 1'b1;
      end
      GW_INFL: begin
        if (req.complete) state_d = rise ? GW_PEND : GW_IDLE;
        else if (rise)    state_d = GW_INFL_PEND;
      end
      GW_INFL_PEND: begin
        ovr_set = rise;
        if (req.complete) state_d = GW_PEND;
      end
      default: state_d = GW_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= GW_IDLE;
      edge_overrun <= 1'b0;
    end else begin
      state_q <= state_d;
      if (ovr_set)              edge_overrun <= 1'b1;
      else if (req.overrun_clr) edge_overrun <= 1'b0;
    end
  end

endmodule

// File: rtl/interrupt_gateway_bank.sv
// Bank of independent interrupt gateways, one cell per source; EDGE_MASK
// selects edge or level semantics per source.
module interrupt_gateway_bank
  import intr_gw_pkg::*;
#(
  parameter int               N_SRC       = 8,
  parameter int               SYNC_STAGES = SYNC_STAGES_DEFAULT,
  parameter logic [N_SRC-1:0] EDGE_MASK   = '0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [N_SRC-1:0] irq_in,
  output logic [N_SRC-1:0] gw_valid,
  input  logic [N_SRC-1:0] gw_ready,
  input  logic [N_SRC-1:0] gw_complete,
  output logic [N_SRC-1:0] edge_overrun,
  input  logic [N_SRC-1:0] overrun_clr
);

  for (genvar i = 0; i < N_SRC; i++) begin : g_src
    gw_plic_req_t req;

    assign req = '{ready: gw_ready[i], complete: gw_complete[i], overrun_clr: overrun_clr[i]};

    interrupt_gateway_cell #(
      .SYNC_STAGES (SYNC_STAGES),
      .IS_EDGE     (EDGE_MASK[i])
    ) u_cell (
      .clock        (clock),
      .reset        (reset),
      .irq          (irq_in[i]),
      .req          (req),
      .gw_valid     (gw_valid[i]),
      .edge_overrun (edge_overrun[i])
    );
  end

endmodule

// File: tb/tb_interrupt_gateway_bank.sv
// Bench for interrupt_gateway_bank: directed scenarios plus a random soak, all
// checked against a rule-level model of each source.
module tb_interrupt_gateway_bank;

  localparam int         N  = 8;
  localparam int         S  = 3;
  localparam logic [7:0] EM = 8'h32;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] irq_in = '0;
  logic [7:0] gw_ready = '0;
  logic [7:0] gw_complete = '0;
  logic [7:0] overrun_clr = '0;
  logic [7:0] gw_valid;
  logic [7:0] edge_overrun;

  int checks = 0;
  int errors = 0;

  // Model: irq samples taken at each edge since reset, plus per-source flags.
  logic [7:0] samp[$];
  logic [7:0] m_pend = '0;
  logic [7:0] m_infl = '0;
  logic [7:0] m_ovr  = '0;

  always #5 clock = ~clock;

  interrupt_gateway_bank #(
    .N_SRC       (N),
    .SYNC_STAGES (S),
    .EDGE_MASK   (EM)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .irq_in       (irq_in),
    .gw_valid     (gw_valid),
    .gw_ready     (gw_ready),
    .gw_complete  (gw_complete),
    .edge_overrun (edge_overrun),
    .overrun_clr  (overrun_clr)
  );

  // Synchronised level seen after e edges: the sample taken S-1 edges earlier.
  function automatic logic [7:0] sync_at(int e);
    if (e - S >= 0 && e - S < samp.size()) return samp[e - S];
    return 8'h00;
  endfunction

  function automatic logic [7:0] exp_valid();
    logic [7:0] s;
    s = sync_at(samp.size());
    return ~m_infl & ((EM & m_pend) | (~EM & s));
  endfunction

  task automatic tick();
    logic [7:0] s, p, rise, acc, set_ovr;
    @(posedge clock);
    if (reset) begin
      samp.delete();
      m_pend = '0;
      m_infl = '0;
      m_ovr  = '0;
    end else begin
      s       = sync_at(samp.size());
      p       = sync_at(samp.size() - 1);
      rise    = s & ~p & EM;
      acc     = exp_valid() & gw_ready;
      set_ovr = rise & m_pend & ~acc;
      m_pend  = EM & ((acc & rise) | (~acc & (m_pend | rise)));
      m_ovr   = set_ovr | (m_ovr & ~overrun_clr);
      m_infl  = acc | (m_infl & ~gw_complete);
      samp.push_back(irq_in);
    end
    #1;
  endtask

  task automatic test_reset();
    tick();
    tick();
    checks++;
    if (gw_valid !== 8'h00) begin errors++; $display("FAIL reset_valid: got %h want 00", gw_valid); end
    checks++;
    if (edge_overrun !== 8'h00) begin errors++; $display("FAIL reset_ovr: got %h want 00", edge_overrun); end
    reset = 1'b0;
    tick();
    checks++;
    if (gw_valid !== 8'h00) begin errors++; $display("FAIL post_reset_valid: got %h want 00", gw_valid); end
  endtask

  task automatic test_level();
    irq_in[0] = 1'b1;
    tick();
    tick();
    checks++;
    if (gw_valid[0] !== 1'b0) begin errors++; $display("FAIL level_lat_early: got %b want 0", gw_valid[0]); end
    tick();
    checks++;
    if (gw_valid[0] !== 1'b1) begin errors++; $display("FAIL level_lat: got %b want 1", gw_valid[0]); end
    checks++;
    if (gw_valid !== exp_valid()) begin errors++; $display("FAIL level_model: got %h want %h", gw_valid, exp_valid()); end
    gw_ready[0] = 1'b1;
    tick();
    gw_ready[0] = 1'b0;
    checks++;
    if (gw_valid[0] !== 1'b0) begin errors++; $display("FAIL level_accept: got %b want 0", gw_valid[0]); end
    tick();
    tick();
    checks++;
    if (gw_valid[0] !== 1'b0) begin errors++; $display("FAIL level_hold_infl: got %b want 0", gw_valid[0]); end
    gw_complete[0] = 1'b1;
    tick();
    gw_complete[0] = 1'b0;
    checks++;
    if (gw_valid[0] !== 1'b1) begin errors++; $display("FAIL level_rereq: got %b want 1", gw_valid[0]); end
    irq_in[0] = 1'b0;
    tick();
    tick();
    checks++;
    if (gw_valid[0] !== 1'b1) begin errors++; $display("FAIL level_drop_early: got %b want 1", gw_valid[0]); end
    tick();
    checks++;
    if (gw_valid[0] !== 1'b0) begin errors++; $display("FAIL level_drop: got %b want 0", gw_valid[0]); end
  endtask

  task automatic test_edge();
    irq_in[1] = 1'b1;
    tick();
    irq_in[1] = 1'b0;
    tick();
    tick();
    checks++;
    if (gw_valid[1] !== 1'b0) begin errors++; $display("FAIL edge_lat_early: got %b want 0", gw_valid[1]); end
    tick();
    checks++;
    if (gw_valid[1] !== 1'b1) begin errors++; $display("FAIL edge_lat: got %b want 1", gw_valid[1]); end
    tick();
    tick();
    checks++;
    if (gw_valid[1] !== 1'b1) begin errors++; $display("FAIL edge_memory: got %b want 1", gw_valid[1]); end
    gw_ready[1] = 1'b1;
    tick();
    gw_ready[1] = 1'b0;
    checks++;
    if (gw_valid[1] !== 1'b0) begin errors++; $display("FAIL edge_accept: got %b want 0", gw_valid[1]); end
    gw_complete[1] = 1'b1;
    tick();
    gw_complete[1] = 1'b0;
    tick();
    checks++;
    if (gw_valid[1] !== 1'b0) begin errors++; $display("FAIL edge_no_rereq: got %b want 0", gw_valid[1]); end
    checks++;
    if (gw_valid !== exp_valid()) begin errors++; $display("FAIL edge_model: got %h want %h", gw_valid, exp_valid()); end
  endtask

  task automatic test_edge_buffer();
    irq_in[1] = 1'b1;
    tick();
    irq_in[1] = 1'b0;
    repeat (3) tick();
    gw_ready[1] = 1'b1;
    tick();
    gw_ready[1] = 1'b0;
    for (int k = 0; k < 2; k++) begin
      irq_in[1] = 1'b1;
      tick();
      irq_in[1] = 1'b0;
      repeat (4) tick();
      if (k == 0) begin
        checks++;
        if (edge_overrun[1] !== 1'b0) begin errors++; $display("FAIL buf_first_edge_ovr: got %b want 0", edge_overrun[1]); end
      end
    end
    checks++;
    if (edge_overrun[1] !== 1'b1) begin errors++; $display("FAIL buf_overrun: got %b want 1", edge_overrun[1]); end
    checks++;
    if (gw_valid[1] !== 1'b0) begin errors++; $display("FAIL buf_valid_infl: got %b want 0", gw_valid[1]); end
    gw_complete[1] = 1'b1;
    tick();
    gw_complete[1] = 1'b0;
    checks++;
    if (gw_valid[1] !== 1'b1) begin errors++; $display("FAIL buf_rereq: got %b want 1", gw_valid[1]); end
    gw_ready[1] = 1'b1;
    tick();
    gw_ready[1] = 1'b0;
    gw_complete[1] = 1'b1;
    tick();
    gw_complete[1] = 1'b0;
    tick();
    tick();
    checks++;
    if (gw_valid[1] !== 1'b0) begin errors++; $display("FAIL buf_single_rereq: got %b want 0", gw_valid[1]); end
    checks++;
    if (edge_overrun[1] !== 1'b1) begin errors++; $display("FAIL buf_ovr_sticky: got %b want 1", edge_overrun[1]); end
    overrun_clr[1] = 1'b1;
    tick();
    overrun_clr[1] = 1'b0;
    checks++;
    if (edge_overrun[1] !== 1'b0) begin errors++; $display("FAIL ovr_clr: got %b want 0", edge_overrun[1]); end
  endtask

  task automatic test_spurious();
    gw_complete[2] = 1'b1;
    gw_ready       = ~gw_valid;
    tick();
    gw_complete[2] = 1'b0;
    gw_ready       = '0;
    checks++;
    if (gw_valid !== 8'h00 || edge_overrun !== 8'h00) begin
      errors++; $display("FAIL spur_outputs: got valid %h ovr %h want 00 00", gw_valid, edge_overrun);
    end
    irq_in[2] = 1'b1;
    repeat (3) tick();
    checks++;
    if (gw_valid !== 8'h04) begin errors++; $display("FAIL spur_state: got %h want 04", gw_valid); end
    gw_ready[2] = 1'b1;
    tick();
    gw_ready[2] = 1'b0;
    irq_in[2]   = 1'b0;
    gw_complete[2] = 1'b1;
    tick();
    gw_complete[2] = 1'b0;
    repeat (4) tick();
    checks++;
    if (gw_valid !== exp_valid()) begin errors++; $display("FAIL spur_cleanup: got %h want %h", gw_valid, exp_valid()); end
  endtask

  task automatic test_reset_midflight();
    irq_in[0] = 1'b1;
    repeat (3) tick();
    gw_ready[0] = 1'b1;
    tick();
    gw_ready[0] = 1'b0;
    checks++;
    if (gw_valid[0] !== 1'b0) begin errors++; $display("FAIL rst_inflight: got %b want 0", gw_valid[0]); end
    #1 reset = 1'b1;
    #1;
    checks++;
    if (gw_valid[0] !== 1'b0) begin errors++; $display("FAIL rst_during: got %b want 0", gw_valid[0]); end
    tick();
    reset = 1'b0;
    tick();
    tick();
    checks++;
    if (gw_valid[0] !== 1'b0) begin errors++; $display("FAIL rst_early: got %b want 0", gw_valid[0]); end
    tick();
    checks++;
    if (gw_valid[0] !== 1'b1) begin errors++; $display("FAIL rst_rereq: got %b want 1", gw_valid[0]); end
    irq_in[0]   = 1'b0;
    gw_ready[0] = 1'b1;
    tick();
    gw_ready[0]    = 1'b0;
    gw_complete[0] = 1'b1;
    tick();
    gw_complete[0] = 1'b0;
    repeat (4) tick();
  endtask

  task automatic test_independence();
    int acc_cnt[N];
    int cmp_cnt[N];
    logic [7:0] acc;
    logic [7:0] cmp;
    for (int i = 0; i < N; i++) begin acc_cnt[i] = 0; cmp_cnt[i] = 0; end
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < N; i++)
        if ($urandom_range(5) == 0) irq_in[i] = ~irq_in[i];
      gw_ready    = 8'($urandom);
      gw_complete = 8'($urandom) & 8'($urandom);
      overrun_clr = ($urandom_range(15) == 0) ? 8'($urandom) : 8'h00;
      acc = gw_valid & gw_ready;
      cmp = gw_complete & m_infl;
      for (int i = 0; i < N; i++) begin
        if (acc[i]) acc_cnt[i]++;
        if (cmp[i]) cmp_cnt[i]++;
      end
      tick();
      checks++;
      if (gw_valid !== exp_valid()) begin
        errors++; $display("FAIL indep_valid c=%0d: got %h want %h", c, gw_valid, exp_valid());
      end
      checks++;
      if (edge_overrun !== m_ovr) begin
        errors++; $display("FAIL indep_ovr c=%0d: got %h want %h", c, edge_overrun, m_ovr);
      end
    end
    for (int i = 0; i < N; i++) begin
      checks++;
      if (acc_cnt[i] - cmp_cnt[i] !== int'(m_infl[i])) begin
        errors++; $display("FAIL indep_scoreboard src%0d: accepts %0d completes %0d inflight %b", i, acc_cnt[i], cmp_cnt[i], m_infl[i]);
      end
    end
    gw_ready    = '0;
    gw_complete = '0;
    overrun_clr = '0;
  endtask

  initial begin
    test_reset();
    test_level();
    test_edge();
    test_edge_buffer();
    test_spurious();
    test_reset_midflight();
    test_independence();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not complete within time limit");
    $fatal(1, "timeout");
  end

endmodule
